// File: rtl/pla_illegal_opc_checker.sv
// Programmable illegal-opcode checker with a one-entry trap latch,
// saturating illegal counter and sticky flag.
module pla_illegal_opc_checker #(
  parameter  int OPC_W   = 10,
  parameter  int ENTRIES = 8,
  parameter  int CNT_W   = 8,
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OPC_W-1:0] in_opc,
  output logic             in_ready,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [OPC_W-1:0] cfg_pat,
  input  logic [OPC_W-1:0] cfg_mask,
  input  logic             cfg_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] out_opc,
  output logic             out_illegal,
  output logic             trap_req,
  output logic [OPC_W-1:0] trap_opc,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             sticky_illegal,
  input  logic             clr_sticky
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  logic [OPC_W-1:0] pat_q  [ENTRIES];
  logic [OPC_W-1:0] mask_q [ENTRIES];
  logic             en_q   [ENTRIES];

  state_t state_q;
  state_t state_d;

  logic hit;
  logic illegal;
  logic accept;
  logic acc_ill;
  logic cap;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (en_q[i] &&
          (((in_opc ^ pat_q[i]) & mask_q[i]) == '0))
        hit = 1'b1;
    end
  end

  assign illegal = in_opc[OPC_W-1] || hit;
  assign acc_ill = accept && illegal;

  // Table updates land after the check, so a same-cycle accept sees the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pat_q[i]  <= '0;
        mask_q[i] <= '0;
        en_q[i]   <= 1'b0;
      end
    end else if (cfg_we) begin
      pat_q[cfg_idx]  <= cfg_pat;
      mask_q[cfg_idx] <= cfg_mask;
      en_q[cfg_idx]   <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_opc     <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_opc     <= in_opc;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc_ill) state_d = PEND;
      PEND: if (trap_ack && !acc_ill) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trap_req = (state_q == PEND);
  end

  // First error wins unless the pending trap is acked in the same cycle
  assign cap = acc_ill && ((state_q == IDLE) || trap_ack);

  always_ff @(posedge clk) begin
    if (rst)      trap_opc <= '0;
    else if (cap) trap_opc <= in_opc;
  end

  always_ff @(posedge clk) begin
    if (rst)
      illegal_cnt <= '0;
    else if (acc_ill && (illegal_cnt != '1))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)             sticky_illegal <= 1'b0;
    else if (acc_ill)    sticky_illegal <= 1'b1;
    else if (clr_sticky) sticky_illegal <= 1'b0;
  end

endmodule

// File: tb/tb_pla_illegal_opc_checker.sv
// Directed bench for pla_illegal_opc_checker with a 4-bit counter.
module tb_pla_illegal_opc_checker;

  localparam int OPC_W = 10;
  localparam int ENT   = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [OPC_W-1:0] in_opc;
  logic             in_ready;
  logic             cfg_we;
  logic [2:0]       cfg_idx;
  logic [OPC_W-1:0] cfg_pat;
  logic [OPC_W-1:0] cfg_mask;
  logic             cfg_en;
  logic             out_valid;
  logic             out_ready;
  logic [OPC_W-1:0] out_opc;
  logic             out_illegal;
  logic             trap_req;
  logic [OPC_W-1:0] trap_opc;
  logic             trap_ack;
  logic [CNT_W-1:0] illegal_cnt;
  logic             sticky_illegal;
  logic             clr_sticky;

  int total = 0;
  int bad   = 0;

  pla_illegal_opc_checker #(
    .OPC_W(OPC_W), .ENTRIES(ENT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_opc(in_opc),
    .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opc(out_opc), .out_illegal(out_illegal),
    .trap_req(trap_req), .trap_opc(trap_opc),
    .trap_ack(trap_ack),
    .illegal_cnt(illegal_cnt),
    .sticky_illegal(sticky_illegal),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_opc = '0;
    cfg_we = 0; cfg_idx = '0; cfg_pat = '0;
    cfg_mask = '0; cfg_en = 0; out_ready = 1;
    trap_ack = 0; clr_sticky = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_oopc", out_opc, 0);
    chk("rst_oill", out_illegal, 0);
    chk("rst_trap", trap_req, 0);
    chk("rst_topc", trap_opc, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_sticky", sticky_illegal, 0);

    rst = 0; in_valid = 1; in_opc = 10'h200;
    settle();
    chk("first_ready", in_ready, 1);
    tick();
    chk("r29_oval", out_valid, 1);
    chk("r29_oill", out_illegal, 1);
    chk("r29_oopc", out_opc, 10'h200);
    chk("r29_trap", trap_req, 1);
    chk("r29_topc", trap_opc, 10'h200);
    chk("r29_cnt", illegal_cnt, 1);
    chk("r29_sticky", sticky_illegal, 1);

    in_valid = 0; trap_ack = 1;
    tick();
    chk("drain_oval", out_valid, 0);
    chk("ack_idle", trap_req, 0);
    tick();
    chk("ack_ignored", trap_req, 0);
    trap_ack = 0;

    in_valid = 1; in_opc = 10'h0A5;
    tick();
    chk("legal_oill", out_illegal, 0);
    chk("legal_cnt", illegal_cnt, 1);

    cfg_we = 1; cfg_idx = 3; cfg_pat = 10'h0A5;
    cfg_mask = 10'h0FF; cfg_en = 1;
    tick();
    chk("old_table", out_illegal, 0);
    chk("old_trap", trap_req, 0);
    cfg_we = 0;

    in_opc = 10'h1A5;
    tick();
    chk("e3_hit_ill", out_illegal, 1);
    chk("e3_hit_opc", out_opc, 10'h1A5);
    chk("e3_trap", trap_opc, 10'h1A5);
    chk("e3_cnt", illegal_cnt, 2);
    in_opc = 10'h0A4;
    tick();
    chk("e3_miss_ill", out_illegal, 0);
    chk("e3_miss_opc", out_opc, 10'h0A4);
    chk("e3_miss_cnt", illegal_cnt, 2);

    in_valid = 0; trap_ack = 1;
    tick();
    trap_ack = 0;
    chk("clear_trap", trap_req, 0);

    out_ready = 0; in_valid = 1; in_opc = 10'h010;
    tick();
    chk("bp_oval", out_valid, 1);
    chk("bp_opc0", out_opc, 10'h010);
    in_opc = 10'h011;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", in_ready, 0);
      tick();
      chk("bp_hold", out_opc, 10'h010);
      chk("bp_vhold", out_valid, 1);
    end
    out_ready = 1;
    settle();
    chk("bp_release", in_ready, 1);
    tick();
    chk("tp_opc1", out_opc, 10'h011);
    in_opc = 10'h012;
    tick();
    chk("tp_opc2", out_opc, 10'h012);
    in_opc = 10'h013;
    tick();
    chk("tp_opc3", out_opc, 10'h013);
    chk("tp_oval", out_valid, 1);

    in_opc = 10'h200;
    tick();
    chk("r32_trap", trap_req, 1);
    chk("r32_topc0", trap_opc, 10'h200);
    in_opc = 10'h300;
    tick();
    chk("r32_first", trap_opc, 10'h200);
    chk("r32_pend", trap_req, 1);
    in_opc = 10'h280; trap_ack = 1;
    tick();
    chk("r32_ackill", trap_req, 1);
    chk("r32_topc1", trap_opc, 10'h280);
    chk("r32_cnt", illegal_cnt, 5);
    in_valid = 0;
    tick();
    trap_ack = 0;
    chk("r32_idle", trap_req, 0);

    clr_sticky = 1;
    tick();
    chk("sticky_clr", sticky_illegal, 0);
    in_valid = 1; in_opc = 10'h200;
    tick();
    chk("sticky_win", sticky_illegal, 1);
    chk("cnt_six", illegal_cnt, 6);
    clr_sticky = 0;

    in_valid = 0;
    cfg_we = 1; cfg_idx = 0; cfg_pat = 10'h155;
    cfg_mask = 10'h000; cfg_en = 1;
    tick();
    cfg_we = 0;
    in_valid = 1; in_opc = 10'h001;
    tick();
    chk("mask0_ill", out_illegal, 1);
    chk("cnt_seven", illegal_cnt, 7);
    for (int i = 1; i < 20; i++) begin
      in_opc = 10'(i + 1);
      tick();
    end
    chk("cnt_sat", illegal_cnt, 15);
    chk("sat_topc", trap_opc, 10'h200);
    chk("sat_trap", trap_req, 1);

    in_valid = 0; out_ready = 0;
    tick();
    chk("pre_rst_oval", out_valid, 1);
    rst = 1; in_valid = 1; in_opc = 10'h300;
    settle();
    chk("rst_cyc_ready", in_ready, 0);
    tick();
    chk("r34_oval", out_valid, 0);
    chk("r34_oopc", out_opc, 0);
    chk("r34_oill", out_illegal, 0);
    chk("r34_trap", trap_req, 0);
    chk("r34_topc", trap_opc, 0);
    chk("r34_cnt", illegal_cnt, 0);
    chk("r34_sticky", sticky_illegal, 0);
    rst = 0; in_valid = 0; out_ready = 1;
    settle();
    chk("r34_ready", in_ready, 1);

    in_valid = 1; in_opc = 10'h001;
    tick();
    chk("post_oval", out_valid, 1);
    chk("post_table", out_illegal, 0);
    in_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_illegal_opc_checker.md
PLA_ILLEGAL_OPC_CHECKER -- requirements
Module: pla_illegal_opc_checker

Interface
Parameters:
REQ-001 SHALL provide parameter OPC_W, default 10, opcode width in bits; bit OPC_W-1 is the reserved-class bit.
REQ-002 SHALL provide parameter ENTRIES, default 8, number of programmable illegal-pattern entries; IDX_W = clog2(ENTRIES).
REQ-003 SHALL provide parameter CNT_W, default 8, illegal-event counter width.
Ports:
REQ-004 SHALL provide: clk  in  1  rising-edge clock.
REQ-005 SHALL provide: rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide: in_valid  in  1  opcode offered; in_opc  in  OPC_W  opcode; in_ready  out  1  checker accepts.
REQ-007 SHALL provide: cfg_we  in  1  table write strobe; cfg_idx  in  IDX_W  entry index; cfg_pat  in  OPC_W  pattern; cfg_mask  in  OPC_W  care bits; cfg_en  in  1  entry enable.
REQ-008 SHALL provide: out_valid  out  1  result valid; out_ready  in  1  consumer accepts; out_opc  out  OPC_W  opcode echo; out_illegal  out  1  verdict.
REQ-009 SHALL provide: trap_req  out  1  trap pending; trap_opc  out  OPC_W  trapped opcode; trap_ack  in  1  trap consumed.
REQ-010 SHALL provide: illegal_cnt  out  CNT_W  count of illegal opcodes; sticky_illegal  out  1  any-illegal flag; clr_sticky  in  1  clear flag.

Function
REQ-011 Entry i SHALL match when en[i]=1 and ((in_opc ^ pat[i]) & mask[i]) == 0; mask=0 with en=1 matches every opcode.
REQ-012 Verdict SHALL be illegal = in_opc[OPC_W-1] OR any entry match.
REQ-013 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; in_ready = !out_valid OR out_ready (0 while rst=1).
REQ-014 Latency SHALL be 1 cycle: out_valid, out_opc and out_illegal register on the accept edge.
REQ-015 While out_valid=1 and out_ready=0, out_opc/out_illegal SHALL hold stable; out_valid clears after a transfer cycle with no new accept.
REQ-016 Back-to-back accepts with out_ready=1 SHALL sustain 1 opcode/cycle without bubbles.
REQ-017 Table write (cfg_we=1) SHALL update entry cfg_idx at the clock edge; an opcode accepted in the same cycle SHALL be checked against the old table.
REQ-018 Trap FSM SHALL have states IDLE and PEND; trap_req = (state==PEND).
REQ-019 IDLE -> PEND on accept of an illegal opcode; trap_opc captures that opcode on the same edge.
REQ-020 PEND -> IDLE on trap_ack=1 with no illegal accept that cycle; trap_ack in IDLE SHALL be ignored.
REQ-021 In PEND, an illegal accept without trap_ack SHALL NOT overwrite trap_opc (first-error wins).
REQ-022 In PEND, trap_ack and an illegal accept in the same cycle SHALL stay PEND with trap_opc = new opcode.
REQ-023 illegal_cnt SHALL increment by 1 per illegal accept and saturate at 2^CNT_W-1.
REQ-024 sticky_illegal SHALL set on illegal accept, clear on clr_sticky=1; set and clear in the same cycle -> set wins.
REQ-025 Legal accepts SHALL not affect trap state, counter, or sticky flag.

Reset
REQ-026 With rst=1 at a clock edge: out_valid=0, out_opc=0, out_illegal=0, trap_req=0 (IDLE), trap_opc=0, illegal_cnt=0, sticky_illegal=0, all entries en=0/pat=0/mask=0.
REQ-027 rst asserted mid-transfer or with trap pending SHALL discard the in-flight result and pending trap; no accept occurs in a reset cycle.
REQ-028 First accept SHALL be possible on the first cycle after rst deasserts.

Verification
REQ-029 Reset, no cfg; in_opc=0x200, out_ready=1 -> next cycle out_valid=1, out_illegal=1, trap_req=1, trap_opc=0x200, illegal_cnt=1.
REQ-030 Write entry 3 pat=0x0A5 mask=0x0FF en=1; opcodes 0x1A5, 0x0A4 -> verdicts 1, 0; write and accept same cycle -> old-table verdict.
REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_opc stable, only one accept; release -> full throughput resumes.
REQ-032 Trap pending on 0x200, then illegal 0x300 without ack -> trap_opc stays 0x200; ack plus illegal 0x280 same cycle -> trap_req=1, trap_opc=0x280.
REQ-033 CNT_W=4, 20 illegal accepts -> illegal_cnt=15; clr_sticky with simultaneous illegal accept -> sticky_illegal=1.
REQ-034 rst asserted while trap_req=1 and out_valid=1 -> next cycle all outputs zero, in_ready=1.
